// File: rtl/action_sequencer.sv
// action_sequencer: turns debounced player buttons and a gravity timer into one-cycle action codes for
// control_fsm. Define AUTO_REPEAT_EN to compile in held left/right auto-repeat.
module action_sequencer #(
    parameter int WIDTH           = 8,
    parameter int GRAVITY_DIV     = 20,
    parameter int SOFT_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_start,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_rotr,
    input  logic             btn_rotl,
    input  logic             btn_drop,
    input  logic             is_move,
    input  logic             is_lose,
    input  logic             is_wait,
    output logic [WIDTH-1:0] action,
    output logic             action_valid,
    output logic             game_over,
    output logic [2:0]       fsm_state
);
    localparam int GW      = $clog2(GRAVITY_DIV + 1);
    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NB      = 6;
    localparam int B_START = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_ROTR  = 3;
    localparam int B_ROTL  = 4;
    localparam int B_DROP  = 5;

    localparam logic [WIDTH-1:0] NOP      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ACT_LOAD = WIDTH'(3'd0);
    localparam logic [WIDTH-1:0] ACT_DOWN = WIDTH'(3'd1);
    localparam logic [WIDTH-1:0] ACT_LEFT = WIDTH'(3'd2);
    localparam logic [WIDTH-1:0] ACT_RGHT = WIDTH'(3'd3);
    localparam logic [WIDTH-1:0] ACT_ROTR = WIDTH'(3'd4);
    localparam logic [WIDTH-1:0] ACT_ROTL = WIDTH'(3'd5);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_PLAY  = 3'd2,
        S_LOCK  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t            state_r, state_next_s;
    logic [NB-1:0]     btn_raw_s, sync1_r, sync2_r, stable_s, accept_s;
    logic [4:0]        pend_r, pend_clr_s, rearm_s;
    logic [GW-1:0]     grav_cnt_r, grav_reload_s;
    logic              tick_s, grav_load_s, down_reject_s;
    logic [WIDTH-1:0]  action_r, act_next_s;
    logic              action_valid_r, valid_next_s, game_over_r;

    assign btn_raw_s = {btn_drop, btn_rotl, btn_rotr, btn_right, btn_left, btn_start};

    // Two-flop synchroniser for every asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {NB{1'b0}};
            sync2_r <= {NB{1'b0}};
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_db
        logic [DW-1:0] cnt_r;
        logic          stable_r;

        assign accept_s[g] = (sync2_r[g] != stable_r) && (cnt_r == DW'(DEBOUNCE_CYCLES - 1));
        assign stable_s[g] = stable_r;

        // Count consecutive cycles the synchronised level differs from the accepted one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r    <= {DW{1'b0}};
                stable_r <= 1'b0;
            end else if (accept_s[g]) begin
                cnt_r    <= {DW{1'b0}};
                stable_r <= sync2_r[g];
            end else if (sync2_r[g] != stable_r) begin
                cnt_r    <= cnt_r + DW'(1'b1);
            end else begin
                cnt_r    <= {DW{1'b0}};
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(8 * SOFT_DIV + 1);

    for (genvar r = B_LEFT; r <= B_RIGHT; r++) begin : g_rep
        logic [RW-1:0] rep_cnt_r;
        logic          rep_first_done_r;
        logic          rep_fire_s;

        assign rep_fire_s = stable_s[r] &&
                            (rep_cnt_r == (rep_first_done_r ? RW'(2 * SOFT_DIV - 1) : RW'(8 * SOFT_DIV - 1)));
        assign rearm_s[r] = rep_fire_s;

        // Repeat timer: long initial delay, then short period, restarted on release or new piece.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep_cnt_r        <= {RW{1'b0}};
                rep_first_done_r <= 1'b0;
            end else if (!stable_s[r] || (state_r == S_SPAWN)) begin
                rep_cnt_r        <= {RW{1'b0}};
                rep_first_done_r <= 1'b0;
            end else if (rep_fire_s) begin
                rep_cnt_r        <= {RW{1'b0}};
                rep_first_done_r <= 1'b1;
            end else begin
                rep_cnt_r        <= rep_cnt_r + RW'(1'b1);
            end
        end
    end
    assign rearm_s[B_START] = 1'b0;
    assign rearm_s[B_ROTR]  = 1'b0;
    assign rearm_s[B_ROTL]  = 1'b0;
`else
    assign rearm_s = 5'b00000;
`endif

    // Pending request flags; a clear from the sequencer beats a press arriving the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 5'b00000;
        end else begin
            pend_r <= (pend_r | (accept_s[4:0] & ~stable_s[4:0]) | rearm_s) & ~pend_clr_s;
        end
    end

    assign grav_reload_s = stable_s[B_DROP] ? GW'(SOFT_DIV - 1) : GW'(GRAVITY_DIV - 1);
    assign tick_s        = (grav_cnt_r == {GW{1'b0}});

    // Gravity timer: loaded on spawn, runs only in PLAY, reloads instead of underflowing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grav_cnt_r <= {GW{1'b0}};
        end else if (grav_load_s) begin
            grav_cnt_r <= grav_reload_s;
        end else if (state_r == S_PLAY) begin
            grav_cnt_r <= tick_s ? grav_reload_s : (grav_cnt_r - GW'(1'b1));
        end else begin
            grav_cnt_r <= grav_cnt_r;
        end
    end

    // control_fsm answers in the cycle our registered action is visible.
    assign down_reject_s = action_valid_r && (action_r == ACT_DOWN) && !is_move;

    // Next-state, next-action and pending-clear decode.
    always_comb begin
        state_next_s = state_r;
        act_next_s   = NOP;
        valid_next_s = 1'b0;
        pend_clr_s   = 5'b00000;
        grav_load_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                pend_clr_s = 5'b11110;
                if (pend_r[B_START]) begin
                    pend_clr_s[B_START] = 1'b1;
                    state_next_s        = S_SPAWN;
                end else begin
                    state_next_s        = S_IDLE;
                end
            end
            S_SPAWN: begin
                pend_clr_s[B_START] = 1'b1;
                grav_load_s         = 1'b1;
                if (is_lose) begin
                    state_next_s = S_OVER;
                end else begin
                    act_next_s   = ACT_LOAD;
                    valid_next_s = 1'b1;
                    state_next_s = S_PLAY;
                end
            end
            S_PLAY: begin
                pend_clr_s[B_START] = 1'b1;
                if (is_lose) begin
                    state_next_s = S_OVER;
                end else if (down_reject_s) begin
                    pend_clr_s   = 5'b11111;
                    state_next_s = S_LOCK;
                end else if (tick_s) begin
                    act_next_s   = ACT_DOWN;
                    valid_next_s = 1'b1;
                end else if (pend_r[B_ROTR]) begin
                    act_next_s         = ACT_ROTR;
                    valid_next_s       = 1'b1;
                    pend_clr_s[B_ROTR] = 1'b1;
                end else if (pend_r[B_ROTL]) begin
                    act_next_s         = ACT_ROTL;
                    valid_next_s       = 1'b1;
                    pend_clr_s[B_ROTL] = 1'b1;
                end else if (pend_r[B_LEFT]) begin
                    act_next_s         = ACT_LEFT;
                    valid_next_s       = 1'b1;
                    pend_clr_s[B_LEFT] = 1'b1;
                end else if (pend_r[B_RIGHT]) begin
                    act_next_s          = ACT_RGHT;
                    valid_next_s        = 1'b1;
                    pend_clr_s[B_RIGHT] = 1'b1;
                end else begin
                    state_next_s = S_PLAY;
                end
            end
            S_LOCK: begin
                pend_clr_s[B_START] = 1'b1;
                if (is_lose) begin
                    state_next_s = S_OVER;
                end else if (!is_wait) begin
                    state_next_s = S_SPAWN;
                end else begin
                    state_next_s = S_LOCK;
                end
            end
            S_OVER: begin
                pend_clr_s = 5'b11110;
                if (pend_r[B_START]) begin
                    pend_clr_s[B_START] = 1'b1;
                    state_next_s        = S_IDLE;
                end else begin
                    state_next_s        = S_OVER;
                end
            end
            default: begin
                pend_clr_s   = 5'b11111;
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State and registered outputs toward control_fsm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            action_r       <= NOP;
            action_valid_r <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            action_r       <= act_next_s;
            action_valid_r <= valid_next_s;
            game_over_r    <= (state_next_s == S_OVER);
        end
    end

    assign action       = action_r;
    assign action_valid = action_valid_r;
    assign game_over    = game_over_r;
    assign fsm_state    = state_r;

endmodule

// File: tb/tb_action_sequencer.sv
// Directed bench for action_sequencer (GRAVITY_DIV=20, SOFT_DIV=4, DEBOUNCE_CYCLES=4); outputs sampled on
// the falling edge, expected latencies hand-derived from press edge to visible action.
module tb_action_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start, btn_left, btn_right, btn_rotr, btn_rotl, btn_drop;
    logic       is_move, is_lose, is_wait;
    logic [7:0] action;
    logic       action_valid, game_over;
    logic [2:0] fsm_state;

    int         n_total = 0;
    int         n_bad   = 0;
    int         cyc_n   = 0;
    int         nop_bad = 0;
    int         log_cyc[$];
    logic [7:0] log_code[$];
    int         base, d;

    action_sequencer #(
        .WIDTH(8), .GRAVITY_DIV(20), .SOFT_DIV(4), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_start(btn_start), .btn_left(btn_left), .btn_right(btn_right),
        .btn_rotr(btn_rotr), .btn_rotl(btn_rotl), .btn_drop(btn_drop),
        .is_move(is_move), .is_lose(is_lose), .is_wait(is_wait),
        .action(action), .action_valid(action_valid),
        .game_over(game_over), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: step to the falling edge and log any action pulse.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (action_valid === 1'b1) begin
            log_cyc.push_back(cyc_n);
            log_code.push_back(action);
        end else if (action !== 8'hFF) begin
            nop_bad++;
        end
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_code.delete();
    endtask

    task automatic wait_code(input logic [7:0] c, input int budget, input string tag, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (action_valid === 1'b1 && action === c) begin
                at = cyc_n;
                break;
            end
        end
        check(tag, (at >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    function automatic int count_code(input logic [7:0] c);
        int n = 0;
        foreach (log_code[i]) if (log_code[i] == c) n++;
        return n;
    endfunction

    function automatic int first_at(input logic [7:0] c);
        foreach (log_code[i]) if (log_code[i] == c) return log_cyc[i];
        return -1;
    endfunction

    function automatic int last_gap(input logic [7:0] c);
        int prev = -1;
        int gap  = -1;
        foreach (log_code[i]) begin
            if (log_code[i] == c) begin
                if (prev >= 0) gap = log_cyc[i] - prev;
                prev = log_cyc[i];
            end
        end
        return gap;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; btn_start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_rotr = 1'b0; btn_rotl = 1'b0; btn_drop = 1'b0;
        is_move = 1'b1; is_lose = 1'b0; is_wait = 1'b0;
        repeat (3) cyc();
        check("reset_out", {action_valid, action, game_over, fsm_state}, {1'b0, 8'hFF, 1'b0, 3'd0});
        rst_n = 1'b1;
        repeat (2) cyc();

        // 1: start -> load fig, then gravity every 20 cycles
        clear_log();
        base = cyc_n;
        btn_start = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            cyc();
            if (i == 10) btn_start = 1'b0;
        end
        check("t1_pulses", log_cyc.size(), 4);
        if (log_cyc.size() >= 4) begin
            check("t1_load_code", log_code[0], 8'd0);
            check("t1_load_lat", log_cyc[0] - base, 8);
            check("t1_down_code", log_code[1], 8'd1);
            check("t1_gap1", log_cyc[1] - log_cyc[0], 20);
            check("t1_gap2", log_cyc[2] - log_cyc[1], 20);
        end
        check("t1_play", fsm_state, 3'd2);

        // 2: 2-cycle bounce rejected, held press gives one left 7 cycles later
        wait_code(8'd1, 25, "t2_sync_a", d);
        clear_log();
        btn_left = 1'b1;
        cyc(); cyc();
        btn_left = 1'b0;
        repeat (10) cyc();
        check("t2_bounce", count_code(8'd2), 0);
        wait_code(8'd1, 25, "t2_sync_b", d);
        clear_log();
        base = cyc_n;
        btn_left = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            if (i == 10) btn_left = 1'b0;
        end
        check("t2_count", count_code(8'd2), 1);
        check("t2_lat", first_at(8'd2) - base, 7);

        // 3: rotR pending on the tick cycle loses to down, issues next cycle
        wait_code(8'd1, 25, "t3_sync", d);
        repeat (13) cyc();
        clear_log();
        btn_rotr = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (i == 10) btn_rotr = 1'b0;
        end
        check("t3_down", first_at(8'd1) - d, 20);
        check("t3_rotr", first_at(8'd4) - d, 21);

        // 4: rejected down -> LOCK while is_wait, then respawn
        wait_code(8'd1, 25, "t4_sync", d);
        is_move = 1'b0;
        is_wait = 1'b1;
        clear_log();
        cyc();
        is_move = 1'b1;
        check("t4_lock", fsm_state, 3'd3);
        repeat (4) cyc();
        check("t4_still_lock", fsm_state, 3'd3);
        is_wait = 1'b0;
        cyc();
        check("t4_spawn", fsm_state, 3'd1);
        cyc();
        check("t4_load", {action_valid, action}, {1'b1, 8'h00});
        check("t4_lock_quiet", log_cyc.size(), 1);

        // 5: loss -> OVER, start -> IDLE, start again -> new game
        is_lose = 1'b1;
        cyc();
        check("t5_over", {game_over, fsm_state}, {1'b1, 3'd4});
        is_lose = 1'b0;
        clear_log();
        repeat (5) cyc();
        check("t5_quiet", log_cyc.size(), 0);
        btn_start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (i == 10) btn_start = 1'b0;
        end
        check("t5_idle", {game_over, fsm_state}, {1'b0, 3'd0});
        repeat (10) cyc();
        check("t5_no_spawn", count_code(8'd0), 0);
        clear_log();
        base = cyc_n;
        btn_start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (i == 10) btn_start = 1'b0;
        end
        check("t5_restart", first_at(8'd0) - base, 8);

        // soft drop shortens the gravity period to 4
        btn_drop = 1'b1;
        clear_log();
        repeat (50) cyc();
        check("t5_soft_gap", last_gap(8'd1), 4);
        btn_drop = 1'b0;
        repeat (8) cyc();

        // 6: reset with left pending
        btn_left = 1'b1;
        repeat (6) cyc();
        rst_n = 1'b0;
        btn_left = 1'b0;
        #1;
        check("t6_rst", {action_valid, action, game_over, fsm_state}, {1'b0, 8'hFF, 1'b0, 3'd0});
        repeat (2) cyc();
        rst_n = 1'b1;
        clear_log();
        repeat (20) cyc();
        check("t6_no_left", count_code(8'd2), 0);
        check("t6_idle", fsm_state, 3'd0);

        check("nop_between", nop_bad, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
